// File: rtl/mem_io_pkg.sv
// Shared constants and types for the memory/I-O responder.
package mem_io_pkg;

    // I/O window register addresses (18-bit decoded address space)
    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CLK  = 18'h30004;

    // addr[17:16] value that selects the I/O window
    localparam logic [1:0]  IO_SEL  = 2'b11;

    // Source of the byte presented on cpu_din in the cycle after a read
    typedef enum logic {
        RD_REG,   // I/O register value or 0x00, captured at the edge
        RD_RAM    // byte read out of the RAM array
    } rd_src_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count-based full/empty and explicit pointer wrap.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage write.
    // NOTE: the storage array has no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy update.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Target side of the CPU byte bus: 128 KB RAM plus UART FIFOs, cycle counter
// and program-stop flag in the I/O window at addr[17:16]==2'b11.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_ADDR_W  = 17,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int TX_CW = $clog2(TX_DEPTH + 1);
    localparam int RX_CW = $clog2(RX_DEPTH + 1);

    logic [17:0]           addr;
    logic                  io_sel;
    logic                  ram_sel;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic                  unused_addr_hi;

    logic [7:0]            ram [2**RAM_ADDR_W];
    logic [7:0]            ram_q;

    logic [31:0]           cycles;
    logic [31:0]           snap;
    logic [7:0]            io_q;
    rd_src_e               rd_src;
    logic                  stop_pend;

    logic [7:0]            io_rd_next;
    logic                  snap_ld;
    logic                  stop_wr;
    logic                  tx_cpu_push;
    logic                  stop_push;
    logic                  rx_pop;

    logic                  tx_push;
    logic [7:0]            tx_din;
    logic                  tx_full;
    logic                  tx_empty;
    logic [TX_CW-1:0]      tx_count;
    logic                  rx_full;
    logic                  rx_empty;
    logic [7:0]            rx_head;
    logic [RX_CW-1:0]      unused_rx_count;

    // Address decode: only bits 17:0 matter; upper bits are don't-care.
    assign addr           = cpu_a[17:0];
    assign unused_addr_hi = ^cpu_a[31:18];
    assign io_sel         = (addr[17:16] == IO_SEL);
    assign ram_sel        = !io_sel && ((addr >> RAM_ADDR_W) == '0);
    assign ram_addr       = addr[RAM_ADDR_W-1:0];

    // I/O access decode: read data, FIFO requests and stop/snapshot strobes.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        io_rd_next  = 8'h00;
        snap_ld     = 1'b0;
        stop_wr     = 1'b0;
        tx_cpu_push = 1'b0;
        rx_pop      = 1'b0;
        if (io_sel) begin
            if (cpu_wr) begin
                if (addr == IO_UART) begin
                    tx_cpu_push = (cpu_dout != 8'h00);
                end else if (addr == IO_CLK) begin
                    stop_wr = 1'b1;
                end
            end else begin
                case (addr)
                    IO_UART: begin
                        io_rd_next = rx_empty ? 8'h00 : rx_head;
                        rx_pop     = !rx_empty;
                    end
                    IO_CLK: begin
                        io_rd_next = cycles[7:0];
                        snap_ld    = 1'b1;
                    end
                    IO_CLK + 18'd1: io_rd_next = snap[15:8];
                    IO_CLK + 18'd2: io_rd_next = snap[23:16];
                    IO_CLK + 18'd3: io_rd_next = snap[31:24];
                    default:        io_rd_next = 8'h00;
                endcase
            end
        end
    end

    // The CPU byte owns the TX push port; a pending stop byte waits for a free, non-full cycle.
    assign stop_push = stop_pend && !tx_full && !tx_cpu_push;
    assign tx_push   = (tx_cpu_push && !tx_full) || stop_push;
    assign tx_din    = tx_cpu_push ? cpu_dout : 8'h00;

    // RAM port: write-through to the array, read registered for the next cycle.
    always_ff @(posedge clk_in) begin
        if (ram_sel && cpu_wr) begin
            ram[ram_addr] <= cpu_dout;
        end
        ram_q <= ram[ram_addr];
    end

    // Counter, snapshot, read-back register and sticky status flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cycles         <= '0;
            snap           <= '0;
            io_q           <= '0;
            rd_src         <= RD_REG;
            stop_pend      <= 1'b0;
            program_stop   <= 1'b0;
            tx_overflow    <= 1'b0;
            io_buffer_full <= 1'b0;
        end else begin
            cycles <= cycles + 32'd1;
            if (snap_ld) begin
                snap <= cycles;
            end
            io_q   <= io_rd_next;
            rd_src <= (ram_sel && !cpu_wr) ? RD_RAM : RD_REG;
            if (stop_push) begin
                stop_pend <= 1'b0;
            end else if (stop_wr && !program_stop) begin
                stop_pend <= 1'b1;
            end
            if (stop_wr) begin
                program_stop <= 1'b1;
            end
            if (tx_cpu_push && tx_full) begin
                tx_overflow <= 1'b1;
            end
            io_buffer_full <= (tx_count >= TX_CW'(TX_DEPTH - FULL_MARGIN));
        end
    end

    assign cpu_din  = (rd_src == RD_RAM) ? ram_q : io_q;
    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (tx_push),
        .pop   (tx_valid && tx_ready),
        .din   (tx_din),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (rx_valid && rx_ready),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (unused_rx_count)
    );

endmodule
